servo_pwm_bank: RTL and testbench

Parametrised multi-channel hobby-servo PWM generator for the arm (claw and joints) on the navigation/manipulator FPGA. It holds one target angle per channel, written over a simple SEL/ANGLE/LOAD strobe, and slews each channel's commanded position toward its target at a frame-synchronous, parameterised rate. It emits glitch-free pulses whose width is latched once per PWM frame. It sits between the arm-sequencing logic (or the switch/button debug front-end) and the servo output pins.

---
 rtl/servo_pwm_bank.sv | 127 ++++++++++++
 tb/tb_servo_pwm_bank.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel hobby-servo PWM generator.
// Each channel holds a target angle, slews its commanded position toward it
// once per step frame, and emits one registered pulse per frame whose width
// and enable are latched only at the frame boundary (glitch-free outputs).
module servo_pwm_bank #(
  parameter int NUM_CH      = 3,
  parameter int PERIOD_CYC  = 2000000,
  parameter int MIN_PULSE   = 100000,
  parameter int STEP_CYC    = 555,
  parameter int ANGLE_MAX   = 180,
  parameter int HOME        = 90,
  parameter int SLEW_FRAMES = 1
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] SEL,
  input  logic [7:0]                                    ANGLE,
  input  logic                                          LOAD,
  input  logic [NUM_CH-1:0]                             EN,
  output logic [NUM_CH-1:0]                             SERVO,
  output logic [NUM_CH-1:0]                             BUSY,
  output logic                                          FRAME
);

  localparam int CNT_W     = $clog2(PERIOD_CYC);
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SDIV_W    = (SLEW_FRAMES > 1) ? $clog2(SLEW_FRAMES) : 1;
  localparam int SDIV_LAST = (SLEW_FRAMES > 1) ? SLEW_FRAMES - 1 : 0;

  localparam logic [7:0]       ANGLE_CAP  = 8'(ANGLE_MAX);
  localparam logic [7:0]       HOME_ANGLE = 8'(HOME);
  localparam logic [CNT_W-1:0] HOME_WIDTH = CNT_W'(MIN_PULSE + STEP_CYC * HOME);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYC - 1);

  // A pulse that could reach the frame end would never fall; refuse to build.
  if ((MIN_PULSE + STEP_CYC * ANGLE_MAX >= PERIOD_CYC) || (ANGLE_MAX > 255)) begin : g_illegal
    $error("servo_pwm_bank: MIN_PULSE + STEP_CYC*ANGLE_MAX must be below PERIOD_CYC and ANGLE_MAX <= 255");
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SDIV_W-1:0] sdiv_q, sdiv_d;
  logic [7:0]        target_q [NUM_CH];
  logic [7:0]        target_d [NUM_CH];
  logic [7:0]        pos_q    [NUM_CH];
  logic [7:0]        pos_d    [NUM_CH];
  logic [CNT_W-1:0]  width_q  [NUM_CH];
  logic [CNT_W-1:0]  width_d  [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] servo_q, servo_d;
  logic              boundary;
  logic              step;
  logic              load_ok;
  logic [7:0]        angle_clamped;

  // Frame counter and slew divider; a step frame is a boundary at divider end.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    boundary = (cnt_q == CNT_LAST);
    step     = boundary && (sdiv_q == SDIV_W'(SDIV_LAST));
    cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
    sdiv_d   = sdiv_q;
    if (boundary) begin
      sdiv_d = (sdiv_q == SDIV_W'(SDIV_LAST)) ? '0 : sdiv_q + SDIV_W'(1);
    end
  end

  // Target writes, position slew, and boundary latching of width/enable.
  always_comb begin
    load_ok       = LOAD && (32'(SEL) < NUM_CH);
    angle_clamped = (ANGLE > ANGLE_CAP) ? ANGLE_CAP : ANGLE;
    en_d          = boundary ? EN : en_q;
    for (int i = 0; i < NUM_CH; i++) begin
      target_d[i] = target_q[i];
      if (load_ok && (SEL == SEL_W'(i))) begin
        target_d[i] = angle_clamped;
      end
      // The step compares against the old target, so a write landing on the
      // boundary only takes effect from the following step frame.
      pos_d[i] = pos_q[i];
      if (step) begin
        if (SLEW_FRAMES == 0) begin
          pos_d[i] = target_q[i];
        end else if (pos_q[i] < target_q[i]) begin
          pos_d[i] = pos_q[i] + 8'd1;
        end else if (pos_q[i] > target_q[i]) begin
          pos_d[i] = pos_q[i] - 8'd1;
        end
      end
      width_d[i] = boundary
                 ? CNT_W'(MIN_PULSE) + CNT_W'(STEP_CYC) * CNT_W'(pos_d[i])
                 : width_q[i];
      servo_d[i] = en_q[i] && (cnt_q < width_q[i]);
      BUSY[i]    = (pos_q[i] != target_q[i]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      sdiv_q  <= '0;
      en_q    <= '0;
      servo_q <= '0;
      // NOTE: these per-channel arrays are a handful of flops, not a RAM, so every element is reset.
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= HOME_ANGLE;
        pos_q[i]    <= HOME_ANGLE;
        width_q[i]  <= HOME_WIDTH;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      cnt_q   <= cnt_d;
      sdiv_q  <= sdiv_d;
      en_q    <= en_d;
      servo_q <= servo_d;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= target_d[i];
        pos_q[i]    <= pos_d[i];
        width_q[i]  <= width_d[i];
      end
    end
  end

  assign SERVO = servo_q;
  assign FRAME = boundary;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank. Three instances share the inputs and
// differ only in SLEW_FRAMES (1, 0 and 2); a negedge monitor counts SERVO
// high cycles over each frame window (cnt 0..999, closed at the FRAME cycle).
module tb_servo_pwm_bank;

  localparam int NCH = 3;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [1:0]     SEL = '0;
  logic [7:0]     ANGLE = '0;
  logic           LOAD = 1'b0;
  logic [NCH-1:0] EN = '0;

  logic [NCH-1:0] servo_a, busy_a, servo_z, busy_z, servo_b, busy_b;
  logic           frame_a, frame_z, frame_b;

  int checks = 0;
  int errors = 0;

  int hi_a[NCH], hi_z[NCH], hi_b[NCH];
  int meas_a[NCH], meas_z[NCH], meas_b[NCH];

  always #5 CLK = ~CLK;

  servo_pwm_bank #(.NUM_CH(3), .PERIOD_CYC(1000), .MIN_PULSE(100), .STEP_CYC(2),
                   .ANGLE_MAX(180), .HOME(90), .SLEW_FRAMES(1)) dut (
    .CLK(CLK), .RST(RST), .SEL(SEL), .ANGLE(ANGLE), .LOAD(LOAD), .EN(EN),
    .SERVO(servo_a), .BUSY(busy_a), .FRAME(frame_a));

  servo_pwm_bank #(.NUM_CH(3), .PERIOD_CYC(1000), .MIN_PULSE(100), .STEP_CYC(2),
                   .ANGLE_MAX(180), .HOME(90), .SLEW_FRAMES(0)) dut_jump (
    .CLK(CLK), .RST(RST), .SEL(SEL), .ANGLE(ANGLE), .LOAD(LOAD), .EN(EN),
    .SERVO(servo_z), .BUSY(busy_z), .FRAME(frame_z));

  servo_pwm_bank #(.NUM_CH(3), .PERIOD_CYC(1000), .MIN_PULSE(100), .STEP_CYC(2),
                   .ANGLE_MAX(180), .HOME(90), .SLEW_FRAMES(2)) dut_slow (
    .CLK(CLK), .RST(RST), .SEL(SEL), .ANGLE(ANGLE), .LOAD(LOAD), .EN(EN),
    .SERVO(servo_b), .BUSY(busy_b), .FRAME(frame_b));

  // Pulse-width monitor: all instances share reset and period, so frames align.
  always @(negedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (RST) begin
        hi_a[i] = 0; hi_z[i] = 0; hi_b[i] = 0;
      end else if (frame_a) begin
        meas_a[i] = hi_a[i] + int'(servo_a[i]); hi_a[i] = 0;
        meas_z[i] = hi_z[i] + int'(servo_z[i]); hi_z[i] = 0;
        meas_b[i] = hi_b[i] + int'(servo_b[i]); hi_b[i] = 0;
      end else begin
        hi_a[i] += int'(servo_a[i]);
        hi_z[i] += int'(servo_z[i]);
        hi_b[i] += int'(servo_b[i]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // Returns 1 time unit after the negedge of the next FRAME cycle.
  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (frame_a !== 1'b1 && cyc < 1100);
    if (frame_a !== 1'b1) begin
      checks++; errors++;
      $display("FAIL frame_timeout waited %0d cycles, required FRAME within 1100", cyc);
    end
    #1;
  endtask

  // Drives a one-cycle LOAD sampled by the next rising edge.
  task automatic drive_load(input logic [1:0] sel, input logic [7:0] ang);
    SEL = sel; ANGLE = ang; LOAD = 1'b1;
    @(posedge CLK);
    #1 LOAD = 1'b0;
  endtask

  task automatic apply_reset(input logic [NCH-1:0] en);
    @(negedge CLK);
    RST = 1'b1; EN = en; LOAD = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({servo_a, busy_a, frame_a} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs servo=%b busy=%b frame=%b, required all 0", servo_a, busy_a, frame_a);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_reset();
    int  cyc;
    bit  quiet = 1'b1;
    apply_reset(3'b111);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (servo_a !== 3'b000 || busy_a !== 3'b000) quiet = 1'b0;
    end while (frame_a !== 1'b1 && cyc < 1100);
    checks++;
    if (!quiet || frame_a !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_quiet quiet=%0d frame=%b after %0d cycles, required quiet=1 frame=1", quiet, frame_a, cyc);
    end
    @(negedge CLK);
    checks++;
    if (servo_a !== 3'b000 || frame_a !== 1'b0) begin
      errors++;
      $display("FAIL after_frame servo=%b frame=%b, required 000 and 0", servo_a, frame_a);
    end
    @(negedge CLK);
    checks++;
    if (servo_a !== 3'b111) begin
      errors++;
      $display("FAIL first_rise servo=%b, required 111", servo_a);
    end
    wait_frame(cyc);
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (meas_a[ch] !== 280 || meas_z[ch] !== 280 || meas_b[ch] !== 280) begin
        errors++;
        $display("FAIL home_width ch%0d got %0d/%0d/%0d, required 280", ch, meas_a[ch], meas_z[ch], meas_b[ch]);
      end
    end
    wait_frame(cyc);
    checks++;
    if (cyc !== 1000 || meas_a[0] !== 280) begin
      errors++;
      $display("FAIL frame_period period=%0d width=%0d, required 1000 and 280", cyc, meas_a[0]);
    end
  endtask

  task automatic test_slew_up();
    int cyc;
    @(negedge CLK);
    drive_load(2'd0, 8'd100);
    checks++;
    if (busy_a !== 3'b001) begin
      errors++;
      $display("FAIL slew_busy_set busy=%b, required 001", busy_a);
    end
    wait_frame(cyc);
    checks++;
    if (meas_a[0] !== 280) begin
      errors++;
      $display("FAIL slew_load_frame ch0 got %0d, required 280", meas_a[0]);
    end
    for (int j = 1; j <= 10; j++) begin
      wait_frame(cyc);
      for (int ch = 0; ch < NCH; ch++) begin
        checks++;
        if (meas_a[ch] !== ((ch == 0) ? 280 + 2 * j : 280)) begin
          errors++;
          $display("FAIL slew_width step%0d ch%0d got %0d, required %0d", j, ch, meas_a[ch], (ch == 0) ? 280 + 2 * j : 280);
        end
      end
      checks++;
      if (busy_a[0] !== ((j < 10) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL slew_busy step%0d got %b, required %b", j, busy_a[0], (j < 10) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic test_clamp_range();
    int cyc;
    @(negedge CLK);
    drive_load(2'd1, 8'd250);
    drive_load(2'd3, 8'd0);
    checks++;
    if (busy_a !== 3'b010) begin
      errors++;
      $display("FAIL clamp_busy busy=%b, required 010", busy_a);
    end
    wait_frame(cyc);
    checks++;
    if (meas_a[1] !== 280 || meas_z[1] !== 280) begin
      errors++;
      $display("FAIL clamp_load_frame ch1 got %0d/%0d, required 280", meas_a[1], meas_z[1]);
    end
    for (int j = 1; j <= 3; j++) begin
      wait_frame(cyc);
      checks++;
      if (meas_a[0] !== 300 || meas_a[1] !== 280 + 2 * j || meas_a[2] !== 280) begin
        errors++;
        $display("FAIL clamp_ramp frame%0d got %0d/%0d/%0d, required 300/%0d/280", j, meas_a[0], meas_a[1], meas_a[2], 280 + 2 * j);
      end
      checks++;
      if (meas_z[0] !== 300 || meas_z[1] !== 460 || meas_z[2] !== 280) begin
        errors++;
        $display("FAIL clamp_jump frame%0d got %0d/%0d/%0d, required 300/460/280", j, meas_z[0], meas_z[1], meas_z[2]);
      end
    end
  endtask

  task automatic test_collision();
    int cyc;
    // Called in the FRAME cycle: the load lands on the boundary edge.
    drive_load(2'd2, 8'd89);
    checks++;
    if (busy_a[2] !== 1'b1) begin
      errors++;
      $display("FAIL collision_busy got %b, required 1", busy_a[2]);
    end
    wait_frame(cyc);
    checks++;
    if (meas_a[2] !== 280 || meas_a[1] !== 288) begin
      errors++;
      $display("FAIL collision_hold ch2=%0d ch1=%0d, required 280 and 288", meas_a[2], meas_a[1]);
    end
    wait_frame(cyc);
    checks++;
    if (meas_a[2] !== 278 || meas_a[1] !== 290) begin
      errors++;
      $display("FAIL collision_step ch2=%0d ch1=%0d, required 278 and 290", meas_a[2], meas_a[1]);
    end
  endtask

  task automatic test_modes();
    int cyc;
    int exp_slow[4];
    exp_slow = '{278, 278, 276, 276};
    apply_reset(3'b111);
    wait_frame(cyc);
    @(negedge CLK);
    drive_load(2'd0, 8'd0);
    wait_frame(cyc);
    checks++;
    if (meas_z[0] !== 280 || meas_b[0] !== 280) begin
      errors++;
      $display("FAIL modes_load_frame got %0d/%0d, required 280/280", meas_z[0], meas_b[0]);
    end
    for (int j = 0; j < 4; j++) begin
      wait_frame(cyc);
      checks++;
      if (meas_z[0] !== 100) begin
        errors++;
        $display("FAIL modes_jump frame%0d got %0d, required 100", j, meas_z[0]);
      end
      checks++;
      if (meas_b[0] !== exp_slow[j]) begin
        errors++;
        $display("FAIL modes_slew2 frame%0d got %0d, required %0d", j, meas_b[0], exp_slow[j]);
      end
    end
  endtask

  task automatic test_enable_reset();
    int cyc;
    apply_reset(3'b111);
    wait_frame(cyc);
    wait_frame(cyc);
    repeat (51) @(negedge CLK);
    checks++;
    if (servo_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_pulse_active got %b, required 1", servo_a[0]);
    end
    EN = 3'b110;
    repeat (10) @(negedge CLK);
    checks++;
    if (servo_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_no_truncate got %b, required 1", servo_a[0]);
    end
    wait_frame(cyc);
    checks++;
    if (meas_a[0] !== 280 || meas_a[1] !== 280) begin
      errors++;
      $display("FAIL en_frame_complete got %0d/%0d, required 280/280", meas_a[0], meas_a[1]);
    end
    wait_frame(cyc);
    checks++;
    if (meas_a[0] !== 0 || meas_a[1] !== 280) begin
      errors++;
      $display("FAIL en_next_frame got %0d/%0d, required 0/280", meas_a[0], meas_a[1]);
    end
    repeat (151) @(negedge CLK);
    checks++;
    if (servo_a !== 3'b110) begin
      errors++;
      $display("FAIL pre_reset_pulse servo=%b, required 110", servo_a);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (servo_a !== 3'b000 || servo_z !== 3'b000 || servo_b !== 3'b000 || busy_a !== 3'b000 || frame_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse servo=%b/%b/%b busy=%b frame=%b, required all 0", servo_a, servo_z, servo_b, busy_a, frame_a);
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slew_up();
    test_clamp_range();
    test_collision();
    test_modes();
    test_enable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
